// File: rtl/bank_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and timing defaults for the per-channel bank command arbiter.
//   bus_cmd_t   : encoding of the registered DRAM command bus stage
//   req_cmd_t   : encoding of the 2-bit per-bank request command
//   arb_state_t : arbiter refresh-sequencing state
// Timing defaults are taken from the CYCLE_* defines when the build supplies
// them, so the arbiter tracks the same numbers as the per-bank FSMs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef CYCLE_TRRD
`define CYCLE_TRRD 4
`endif
`ifndef CYCLE_TCCD
`define CYCLE_TCCD 4
`endif
`ifndef CYCLE_TRFC
`define CYCLE_TRFC 88
`endif

package arb_pkg;

   localparam int NUM_BANKS_DEF  = 8;
   localparam int BA_BITS_DEF    = 3;
   localparam int CNT_W_DEF      = 8;
   localparam int CYCLE_TRRD_DEF = `CYCLE_TRRD;
   localparam int CYCLE_TCCD_DEF = `CYCLE_TCCD;
   localparam int CYCLE_TRFC_DEF = `CYCLE_TRFC;

   typedef enum logic [2:0] {
      BUS_NOP   = 3'd0,
      BUS_ACT   = 3'd1,
      BUS_READ  = 3'd2,
      BUS_WRITE = 3'd3,
      BUS_PRE   = 3'd4,
      BUS_REF   = 3'd5
   } bus_cmd_t;

   typedef enum logic [1:0] {
      REQ_ACT   = 2'd0,
      REQ_READ  = 2'd1,
      REQ_WRITE = 2'd2,
      REQ_PRE   = 2'd3
   } req_cmd_t;

   typedef enum logic [1:0] {
      S_NORMAL = 2'd0,
      S_DRAIN  = 2'd1,
      S_REF    = 2'd2
   } arb_state_t;

   // Bus encoding is the request encoding shifted up by one (0 is NOP).
   function automatic bus_cmd_t toBusCmd(input req_cmd_t c);
      return bus_cmd_t'({1'b0, c} + 3'd1);
   endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin picker: finds the first set bit of the
// eligible vector searching upward from the round-robin pointer, wrapping
// modulo NUM_BANKS.
//   i_eligible  : per-bank eligibility
//   i_rr_ptr    : bank with highest priority this cycle
//   o_grant_oh  : one-hot grant (all zero when nothing is eligible)
//   o_grant_idx : encoded index of the granted bank (0 when none)
//   o_found     : at least one bank was eligible
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rr_picker
   import arb_pkg::*;
#(
   parameter int NUM_BANKS = NUM_BANKS_DEF,
   parameter int BA_BITS   = BA_BITS_DEF
) (
   input  logic [NUM_BANKS-1:0] i_eligible,
   input  logic [BA_BITS-1:0]   i_rr_ptr,
   output logic [NUM_BANKS-1:0] o_grant_oh,
   output logic [BA_BITS-1:0]   o_grant_idx,
   output logic                 o_found
);

   // Walk the banks in priority order; the first hit wins and later hits are
   // masked by o_found.
   always_comb begin : pickLoop
      int w_j;
      w_j         = 0;
      o_grant_oh  = '0;
      o_grant_idx = '0;
      o_found     = 1'b0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         w_j = (int'(i_rr_ptr) + k) % NUM_BANKS;
         if (!o_found && i_eligible[w_j]) begin
            o_found         = 1'b1;
            o_grant_idx     = BA_BITS'(w_j);
            o_grant_oh[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bank_cmd_arbiter
// Per-channel command scheduler between the per-bank command FSMs and the
// DRAM command bus. Picks at most one eligible bank per cycle round-robin,
// enforces tRRD/tCCD across banks and sequences all-bank refresh.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_req_valid    : bank i has a pending command
//   i_req_cmd      : bank i command in bits [2i+1:2i] (ACT/READ/WRITE/PRE)
//   i_bank_ready   : bank i per-bank timing has expired
//   i_bank_open    : bank i has an open row
//   i_ref_req      : level refresh request, held until o_ref_ack
//   o_req_ack      : combinational one-hot acceptance
//   o_grant_valid  : registered command-on-bus strobe
//   o_grant_bank   : registered bank of the issued command
//   o_grant_cmd    : registered bus command (bus_cmd_t encoding)
//   o_ref_ack      : registered pulse coincident with REF on the bus
//   o_ref_busy     : arbiter is draining or refreshing
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bank_cmd_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_BANKS  = NUM_BANKS_DEF,
   parameter int BA_BITS    = BA_BITS_DEF,
   parameter int CYCLE_TRRD = CYCLE_TRRD_DEF,
   parameter int CYCLE_TCCD = CYCLE_TCCD_DEF,
   parameter int CYCLE_TRFC = CYCLE_TRFC_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BANKS-1:0]   i_req_valid,
   input  logic [2*NUM_BANKS-1:0] i_req_cmd,
   input  logic [NUM_BANKS-1:0]   i_bank_ready,
   input  logic [NUM_BANKS-1:0]   i_bank_open,
   input  logic                   i_ref_req,
   output logic [NUM_BANKS-1:0]   o_req_ack,
   output logic                   o_grant_valid,
   output logic [BA_BITS-1:0]     o_grant_bank,
   output logic [2:0]             o_grant_cmd,
   output logic                   o_ref_ack,
   output logic                   o_ref_busy
);

   localparam logic [CNT_W-1:0] L_TRRD_LOAD = CNT_W'(CYCLE_TRRD - 1);
   localparam logic [CNT_W-1:0] L_TCCD_LOAD = CNT_W'(CYCLE_TCCD - 1);
   localparam logic [CNT_W-1:0] L_TRFC_LOAD = CNT_W'(CYCLE_TRFC - 1);

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   logic [BA_BITS-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]     r_trrd_cnt;
   logic [CNT_W-1:0]     r_tccd_cnt;
   logic [CNT_W-1:0]     r_rfc_cnt;
   logic                 r_grant_valid;
   logic [BA_BITS-1:0]   r_grant_bank;
   bus_cmd_t             r_grant_cmd;
   logic                 r_ref_ack;

   logic [NUM_BANKS-1:0] w_eligible;
   logic [NUM_BANKS-1:0] w_grant_oh;
   logic [BA_BITS-1:0]   w_grant_idx;
   logic                 w_found;
   req_cmd_t             w_ack_cmd;
   logic                 w_drain_done;

   // Per-bank eligibility. Gating uses the registered state, so a request
   // seen in the cycle ref_req rises still goes out. Nothing is accepted
   // while reset is asserted, keeping req_ack quiet during reset.
   always_comb begin : eligibility
      req_cmd_t w_c;
      logic     w_ok;
      w_c        = REQ_ACT;
      w_ok       = 1'b0;
      w_eligible = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         w_c = req_cmd_t'(i_req_cmd[2*i +: 2]);
         case (w_c)
            REQ_ACT:             w_ok = (r_state == S_NORMAL) && (r_trrd_cnt == '0);
            REQ_READ, REQ_WRITE: w_ok = (r_state == S_NORMAL) && (r_tccd_cnt == '0);
            REQ_PRE:             w_ok = (r_state == S_NORMAL) || (r_state == S_DRAIN);
            default:             w_ok = 1'b0;
         endcase
         w_eligible[i] = rst_n && i_req_valid[i] && i_bank_ready[i] && w_ok;
      end
   end

   rr_picker #(
      .NUM_BANKS (NUM_BANKS),
      .BA_BITS   (BA_BITS)
   ) u_picker (
      .i_eligible  (w_eligible),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant_oh  (w_grant_oh),
      .o_grant_idx (w_grant_idx),
      .o_found     (w_found)
   );

   assign w_ack_cmd = req_cmd_t'(i_req_cmd[2*w_grant_idx +: 2]);

   // In S_DRAIN only PREs are eligible, so !w_found means no PRE this cycle.
   assign w_drain_done = (r_state == S_DRAIN) && (i_bank_open == '0) &&
                         (&i_bank_ready) && !w_found;

   // Refresh sequencing next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_NORMAL: if (i_ref_req)         w_state_next = S_DRAIN;
         S_DRAIN:  if (w_drain_done)      w_state_next = S_REF;
         S_REF:    if (r_rfc_cnt == '0)   w_state_next = S_NORMAL;
         default:                         w_state_next = S_NORMAL;
      endcase
   end

   // State register, inter-bank timing counters and the command bus stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_NORMAL;
         r_rr_ptr      <= '0;
         r_trrd_cnt    <= '0;
         r_tccd_cnt    <= '0;
         r_rfc_cnt     <= '0;
         r_grant_valid <= 1'b0;
         r_grant_bank  <= '0;
         r_grant_cmd   <= BUS_NOP;
         r_ref_ack     <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_found && (w_ack_cmd == REQ_ACT))
            r_trrd_cnt <= L_TRRD_LOAD;
         else if (r_trrd_cnt != '0)
            r_trrd_cnt <= r_trrd_cnt - 1'b1;

         if (w_found && ((w_ack_cmd == REQ_READ) || (w_ack_cmd == REQ_WRITE)))
            r_tccd_cnt <= L_TCCD_LOAD;
         else if (r_tccd_cnt != '0)
            r_tccd_cnt <= r_tccd_cnt - 1'b1;

         if (w_drain_done)
            r_rfc_cnt <= L_TRFC_LOAD;
         else if ((r_state == S_REF) && (r_rfc_cnt != '0))
            r_rfc_cnt <= r_rfc_cnt - 1'b1;

         r_ref_ack <= w_drain_done;
         if (w_found) begin
            r_grant_valid <= 1'b1;
            r_grant_bank  <= w_grant_idx;
            r_grant_cmd   <= toBusCmd(w_ack_cmd);
            r_rr_ptr      <= (w_grant_idx == BA_BITS'(NUM_BANKS - 1)) ?
                             '0 : w_grant_idx + 1'b1;
         end else if (w_drain_done) begin
            r_grant_valid <= 1'b1;
            r_grant_bank  <= '0;
            r_grant_cmd   <= BUS_REF;
         end else begin
            r_grant_valid <= 1'b0;
            r_grant_cmd   <= BUS_NOP;
         end
      end
   end

   assign o_req_ack     = w_grant_oh;
   assign o_grant_valid = r_grant_valid;
   assign o_grant_bank  = r_grant_bank;
   assign o_grant_cmd   = r_grant_cmd;
   assign o_ref_ack     = r_ref_ack;
   assign o_ref_busy    = (r_state != S_NORMAL);

   // At most one bank may be accepted per cycle.
   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_req_ack));

   // The refresh request must stay up until the REF has been issued.
   assert property (@(posedge clk) disable iff (!rst_n)
                    (r_state == S_DRAIN) |-> i_ref_req);

endmodule
